// File: rtl/sfp_tx_pkg.sv
// Shared definitions for the DDR frame reader.
//   state_t         : frame reader FSM states
//   line_t          : one 256-bit DDR line viewed as eight 32-bit words
//   DEFAULT_*       : default frame length limit and read timeout
//   empty_bytes()   : unused byte count in the last word for a given length
package sfp_tx_pkg;

    localparam int DEFAULT_MAX_LEN = 2048;
    localparam int DEFAULT_TIMEOUT = 1023;
    localparam int LINE_WORDS      = 8;
    localparam int WORD_W          = 32;
    localparam int ADR_W           = 25;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        CHECK,
        LINE_REQ,
        LINE_WAIT,
        SEND,
        FINISH,
        FAIL
    } state_t;

    // (4 - L mod 4) mod 4 is just the two's complement of L[1:0]
    function automatic logic [1:0] empty_bytes(input logic [1:0] len_lo);
        return 2'd0 - len_lo;
    endfunction

endpackage

// File: rtl/ddr_line_serializer.sv
// Selects one 32-bit word out of the buffered 256-bit line and generates the
// stream framing flags for it. Purely combinational; the caller keeps
// word_idx and the line stable while a word is stalled.
//   valid    in   word is being presented (all outputs are zero otherwise)
//   line     in   buffered DDR line, word 0 at bits [31:0]
//   word_idx in   global word index within the frame
//   last_idx in   index of the final word (W-1)
//   len_lo   in   frame length bits [1:0]
//   data     out  selected payload word
//   sop/eop  out  first / last word of the frame
//   empty    out  unused bytes in the eop word
module ddr_line_serializer
    import sfp_tx_pkg::*;
(
    input  logic        valid,
    input  line_t       line,
    input  logic [14:0] word_idx,
    input  logic [14:0] last_idx,
    input  logic [1:0]  len_lo,
    output logic [31:0] data,
    output logic        sop,
    output logic        eop,
    output logic [1:0]  empty
);

    always_comb begin
        data  = '0;
        sop   = 1'b0;
        eop   = 1'b0;
        empty = '0;
        if (valid) begin
            // lines are word-aligned, so the low index bits pick the word
            data  = line[word_idx[2:0]];
            sop   = (word_idx == '0);
            eop   = (word_idx == last_idx);
            empty = eop ? empty_bytes(len_lo) : 2'd0;
        end
    end

endmodule

// File: rtl/ddr_frame_reader_256.sv
// Reads a length-prefixed frame from DDR (header line, then payload lines)
// and streams the payload as 32-bit words with sop/eop/empty framing.
//   clk, reset        clock, async active-high reset
//   start, base_adr   begin a frame read at the given header line address
//   rd_rq, rd_adr     one-cycle DDR line read request
//   rd_valid, rd_data returned line
//   tx_*              payload stream (valid/ready handshake)
//   busy, done, err   status; done/err are one-cycle pulses
// TIMEOUT is expected to be at least 2.
module ddr_frame_reader_256
    import sfp_tx_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [24:0]  base_adr,
    output logic         rd_rq,
    output logic [24:0]  rd_adr,
    input  logic         rd_valid,
    input  logic [255:0] rd_data,
    output logic [31:0]  tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_sop,
    output logic         tx_eop,
    output logic [1:0]   tx_empty,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_LEN_V = 17'(MAX_LEN);

    state_t        state;
    logic [24:0]   base;
    logic [15:0]   len;
    line_t         line_buf;
    logic [14:0]   word_idx;
    logic [TW-1:0] timer;

    logic [14:0]   last_idx;
    logic [14:0]   next_word;
    logic          len_bad;
    logic          timeout_hit;

    assign last_idx    = 15'(({1'b0, len} + 17'd3) >> 2) - 15'd1;
    assign next_word   = word_idx + 15'd1;
    assign len_bad     = (len == '0) || ({1'b0, len} > MAX_LEN_V);
    // timer holds the number of cycles since rd_rq, so err lands exactly
    // TIMEOUT cycles after the request
    assign timeout_hit = (timer >= TW'(TIMEOUT - 1));

    function automatic logic [24:0] line_adr(input logic [14:0] idx);
        return base + 25'd1 + {13'd0, idx[14:3]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_rq    <= 1'b0;
            rd_adr   <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            base     <= '0;
            len      <= '0;
            line_buf <= '0;
            word_idx <= '0;
            timer    <= '0;
        end else begin
            rd_rq <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR_REQ;
                        busy     <= 1'b1;
                        base     <= base_adr;
                        rd_rq    <= 1'b1;
                        rd_adr   <= base_adr;
                        timer    <= '0;
                        word_idx <= '0;
                    end
                end
                HDR_REQ: begin
                    state <= HDR_WAIT;
                    timer <= timer + TW'(1);
                end
                HDR_WAIT: begin
                    if (rd_valid) begin
                        len   <= rd_data[15:0];
                        state <= CHECK;
                    end else if (timeout_hit) begin
                        state <= FAIL;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CHECK: begin
                    if (len_bad) begin
                        state <= FAIL;
                        err   <= 1'b1;
                    end else begin
                        state  <= LINE_REQ;
                        rd_rq  <= 1'b1;
                        rd_adr <= line_adr(word_idx);
                        timer  <= '0;
                    end
                end
                LINE_REQ: begin
                    state <= LINE_WAIT;
                    timer <= timer + TW'(1);
                end
                LINE_WAIT: begin
                    if (rd_valid) begin
                        line_buf <= rd_data;
                        state    <= SEND;
                        tx_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        state <= FAIL;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        word_idx <= next_word;
                        if (word_idx == last_idx) begin
                            state    <= FINISH;
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                        end else if (word_idx[2:0] == 3'd7) begin
                            // line exhausted: drop valid and fetch the next one
                            state    <= LINE_REQ;
                            tx_valid <= 1'b0;
                            rd_rq    <= 1'b1;
                            rd_adr   <= line_adr(next_word);
                            timer    <= '0;
                        end
                    end
                end
                FINISH, FAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ddr_line_serializer u_ser (
        .valid    (tx_valid),
        .line     (line_buf),
        .word_idx (word_idx),
        .last_idx (last_idx),
        .len_lo   (len[1:0]),
        .data     (tx_data),
        .sop      (tx_sop),
        .eop      (tx_eop),
        .empty    (tx_empty)
    );

endmodule

// File: tb/tb_ddr_frame_reader_256.sv
module tb_ddr_frame_reader_256;
    import sfp_tx_pkg::*;

    localparam int MAX_LEN = 128;
    localparam int TIMEOUT = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [24:0]  base_adr = '0;
    logic         rd_rq;
    logic [24:0]  rd_adr;
    logic         rd_valid = 1'b0;
    logic [255:0] rd_data = '0;
    logic [31:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         tx_sop, tx_eop;
    logic [1:0]   tx_empty;
    logic         busy, done, err;

    always #5 clk = ~clk;

    ddr_frame_reader_256 #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
        .rd_rq(rd_rq), .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [15:0] len;
        logic [24:0] base;
        int          lat;
        int          mode;       // 0: tx_ready always 1, 1: random
        int          exp_reads;
        int          exp_words;
        logic [1:0]  exp_empty;
        int          exp_done;
        int          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } word_t;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- DDR model ----------------
    logic [24:0] cur_base = '0;
    logic [15:0] hdr_len = '0;
    int          lat = 1;
    bit          resp_en = 1'b1;
    int          ready_mode = 0;
    logic [24:0] resp_adr;

    function automatic logic [31:0] pat_word(input logic [24:0] a, input int k);
        return {a[11:0], 4'(k), ~a[15:0]};
    endfunction

    function automatic line_t pat_line(input logic [24:0] a);
        line_t l;
        for (int k = 0; k < 8; k++) l[k] = pat_word(a, k);
        return l;
    endfunction

    function automatic logic [255:0] hdr_line(input logic [15:0] l);
        return {{7{32'hDEADBEEF}}, 16'hC0DE, l};
    endfunction

    always @(negedge clk) begin
        if (rd_rq && resp_en && !reset) begin
            resp_adr = rd_adr;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1;
            rd_data  = (resp_adr == cur_base) ? hdr_line(hdr_len) : pat_line(resp_adr);
            rd_valid = 1'b1;
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        tx_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    logic [24:0] rq_q[$];
    word_t       tx_q[$];
    int          done_cnt = 0, err_cnt = 0, tv_cnt = 0;
    int          rq_cyc = 0, err_cyc = 0;
    bit          hold = 1'b0;
    logic [35:0] held;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rd_rq) begin
            rq_q.push_back(rd_adr);
            rq_cyc = cyc;
        end
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_valid) tv_cnt++;
        if (hold && !reset)
            check("hold_stable", {tx_valid, tx_sop, tx_eop, tx_empty, tx_data}, {1'b1, held});
        if (tx_valid && tx_ready) tx_q.push_back('{tx_data, tx_sop, tx_eop, tx_empty});
        hold = tx_valid && !tx_ready && !reset;
        held = {tx_sop, tx_eop, tx_empty, tx_data};
    end

    task automatic clear_mon();
        rq_q.delete();
        tx_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        tv_cnt   = 0;
    endtask

    task automatic pulse_start(input logic [24:0] b);
        base_adr = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        for (int c = 0; c < budget && done_cnt == 0 && err_cnt == 0; c++) @(posedge clk);
        check({name, "_end_seen"}, (done_cnt + err_cnt) != 0, 1);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        string p;
        int    n;
        word_t w;
        logic  last;
        p = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        clear_mon();
        hdr_len = v.len; cur_base = v.base; lat = v.lat; ready_mode = v.mode; resp_en = 1'b1;
        pulse_start(v.base);
        @(negedge clk);
        check({p, "_hdr_rq"}, {busy, rd_rq, rd_adr}, {2'b11, v.base});
        wait_end(p, 4000);
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 0;
        check({p, "_reads"}, rq_q.size(), v.exp_reads);
        n = (rq_q.size() < v.exp_reads) ? rq_q.size() : v.exp_reads;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_rd_adr%0d", p, i), rq_q[i], 25'(v.base + 25'(i)));
        check({p, "_words"}, tx_q.size(), v.exp_words);
        n = (tx_q.size() < v.exp_words) ? tx_q.size() : v.exp_words;
        for (int j = 0; j < n; j++) begin
            w    = tx_q[j];
            last = (j == v.exp_words - 1);
            check($sformatf("%s_data%0d", p, j), w.data, pat_word(25'(v.base + 25'd1 + 25'(j / 8)), j % 8));
            check($sformatf("%s_flags%0d", p, j), {w.sop, w.eop, w.empty},
                  {(j == 0), last, last ? v.exp_empty : 2'd0});
        end
        check({p, "_done"}, done_cnt, v.exp_done);
        check({p, "_err"}, err_cnt, v.exp_err);
        check({p, "_busy_idle"}, busy, 0);
        if (v.exp_words == 0) check({p, "_no_tx_valid"}, tv_cnt, 0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'd64,  25'h100,     1, 0, 3, 16, 2'd0, 1, 0};
        vecs[1]  = '{16'd5,   25'h200,     3, 0, 2,  2, 2'd3, 1, 0};
        vecs[2]  = '{16'd0,   25'h300,     1, 0, 1,  0, 2'd0, 0, 1};
        vecs[3]  = '{16'd129, 25'h300,     2, 0, 1,  0, 2'd0, 0, 1};
        vecs[4]  = '{16'd128, 25'h400,     1, 0, 5, 32, 2'd0, 1, 0};
        vecs[5]  = '{16'd1,   25'h500,     1, 0, 2,  1, 2'd3, 1, 0};
        vecs[6]  = '{16'd33,  25'h600,     2, 0, 3,  9, 2'd3, 1, 0};
        vecs[7]  = '{16'd30,  25'h700,     1, 0, 2,  8, 2'd2, 1, 0};
        vecs[8]  = '{16'd40,  25'h1FFFFFF, 1, 0, 3, 10, 2'd0, 1, 0};
        vecs[9]  = '{16'd64,  25'h800,     2, 1, 3, 16, 2'd0, 1, 0};
        vecs[10] = '{16'd7,   25'h900,     4, 1, 2,  2, 2'd1, 1, 0};

        // reset state
        #12;
        check("reset_rd", {rd_rq, rd_adr, busy, done, err}, '0);
        check("reset_tx", {tx_valid, tx_sop, tx_eop, tx_empty, tx_data}, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) run_frame(i, vecs[i]);

        // header read never answered -> err TIMEOUT cycles after rd_rq
        @(posedge clk);
        #1;
        clear_mon();
        resp_en = 1'b0;
        cur_base = 25'hA00;
        pulse_start(25'hA00);
        wait_end("tmo", 200);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_latency", err_cyc - rq_cyc, TIMEOUT);
        check("tmo_err_done", {err_cnt[7:0], done_cnt[7:0]}, {8'd1, 8'd0});
        check("tmo_reads", rq_q.size(), 1);
        check("tmo_idle", {busy, 1'b0}, 2'b00);
        check("tmo_no_tx_valid", tv_cnt, 0);
        resp_en = 1'b1;

        // start while busy is ignored
        @(posedge clk);
        #1;
        clear_mon();
        hdr_len = 16'd5; cur_base = 25'hB00; lat = 6;
        pulse_start(25'hB00);
        @(posedge clk);
        #1;
        pulse_start(25'hC00);
        wait_end("busy_start", 500);
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_reads", rq_q.size(), 2);
        check("busy_start_done", done_cnt, 1);
        check("busy_start_words", tx_q.size(), 2);

        // reset during SEND of the second line
        @(posedge clk);
        #1;
        clear_mon();
        hdr_len = 16'd64; cur_base = 25'h100; lat = 1;
        pulse_start(25'h100);
        for (int c = 0; c < 500 && tx_q.size() < 10; c++) @(posedge clk);
        check("mid_reached_line2", tx_q.size() >= 10, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_rd", {rd_rq, rd_adr, busy, done, err}, '0);
        check("mid_reset_tx", {tx_valid, tx_sop, tx_eop, tx_empty, tx_data}, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_abandon", {done_cnt[7:0], err_cnt[7:0]}, '0);
        run_frame(20, vecs[0]);

        // reset wins over a simultaneous start
        @(posedge clk);
        #1;
        clear_mon();
        reset = 1'b1;
        start = 1'b1;
        base_adr = 25'h100;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_start_reads", rq_q.size(), 0);
        check("rst_start_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/ddr_frame_reader_256.md
DDR_FRAME_READER_256 -- requirements
Module: ddr_frame_reader_256

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL have parameter MAX_LEN, default 2048, giving the largest legal frame length in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 1023, giving the maximum clk cycles allowed from rd_rq to rd_valid.
REQ-004 clk  in  1  system clock (clk_125_tx_rx domain).
REQ-005 reset  in  1  async active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame read; ignored while busy.
REQ-007 base_adr  in  25  DDR line address of the frame header.
REQ-008 rd_rq  out  1  one-cycle read request to the DDR request port.
REQ-009 rd_adr  out  25  line address; valid while rd_rq=1.
REQ-010 rd_valid  in  1  read data return strobe.
REQ-011 rd_data  in  256  returned line.
REQ-012 tx_data  out  32  payload word; bytes are little-endian within the line, with word 0 at bits [31:0].
REQ-013 tx_valid / tx_ready  out / in  1 / 1  stream handshake.
REQ-014 tx_sop, tx_eop  out  1  first word / last word of the frame.
REQ-015 tx_empty  out  2  count of unused bytes in the eop word; 0 on all other words.
REQ-016 busy  out  1  high from the cycle after an accepted start until done or err.
REQ-017 done, err  out  1  one-cycle completion pulse / one-cycle error pulse.

Function
REQ-018 Header line at base_adr: bits[15:0] = frame length L in bytes; all other bits are ignored.
REQ-019 Payload occupies lines base_adr+1 .. base_adr+NL, with W=ceil(L/4) words and NL=ceil(W/8); all address arithmetic wraps modulo 2^25.
REQ-020 FSM states: IDLE, HDR_REQ, HDR_WAIT, CHECK, LINE_REQ, LINE_WAIT, SEND, FINISH, FAIL.
REQ-021 IDLE -> HDR_REQ on start; HDR_REQ asserts rd_rq for exactly one cycle, then moves to HDR_WAIT.
REQ-022 HDR_WAIT -> CHECK on rd_valid; L is latched from that same cycle's rd_data.
REQ-023 CHECK: L=0 or L>MAX_LEN -> FAIL; otherwise -> LINE_REQ.
REQ-024 LINE_REQ: one-cycle rd_rq at base_adr+1+line_idx, then LINE_WAIT; only one read outstanding at any time.
REQ-025 LINE_WAIT -> SEND on rd_valid, capturing rd_data into a 256-bit line buffer.
REQ-026 SEND: presents buffer words 0..7 in order; a word transfers when tx_valid&tx_ready.
REQ-027 SEND: tx_data, tx_sop, tx_eop and tx_empty SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-028 SEND -> LINE_REQ after word 7 of a non-final line; SEND -> FINISH after word W-1.
REQ-029 Words beyond W-1 in the final line SHALL NOT be sent.
REQ-030 tx_valid SHALL drop between lines; gaps in the stream are legal.
REQ-031 tx_sop=1 only on global word 0; tx_eop=1 only on word W-1; a one-word frame asserts both on that word.
REQ-032 tx_empty = (4 - L mod 4) mod 4 on the eop word.
REQ-033 FINISH: pulse done for one cycle, then -> IDLE. FAIL: pulse err for one cycle, then -> IDLE.
REQ-034 Latency: rd_rq for the header SHALL be asserted in the cycle after start is sampled.
REQ-035 Minimum gap from rd_valid to the first tx_valid is 1 cycle.
REQ-036 In HDR_WAIT/LINE_WAIT a timeout counter runs; reaching TIMEOUT cycles without rd_valid -> FAIL; the counter clears on every rd_rq.
REQ-037 rd_valid arriving outside the WAIT states SHALL be ignored.
REQ-038 start during busy SHALL be ignored (no queueing).
REQ-039 tx_ready SHALL be ignored while tx_valid=0.

Reset
REQ-040 On reset assertion, in any state, the FSM SHALL go to IDLE immediately, abandoning any frame in progress without done or err.
REQ-041 Reset values: rd_rq=0, rd_adr=0, tx_valid=0, tx_data=0, tx_sop=0, tx_eop=0, tx_empty=0, busy=0, done=0, err=0, line buffer=0, all counters=0.
REQ-042 Reset SHALL take priority over a simultaneous start.

Structure
REQ-043 Package sfp_tx_pkg SHALL hold the FSM state enum, the default MAX_LEN and TIMEOUT values, and the LINE_WORDS=8 constant.
REQ-044 The 256->32 word selection, with its sop/eop/empty generation, SHALL be a sub-module named ddr_line_serializer; the FSM and request logic SHALL stay in the top module.

Verification
REQ-045 Header L=0x40, tx_ready=1 -> two line reads at base+1 and base+2; 16 words sent; sop on word 0; eop on word 15 with tx_empty=0; one done pulse.
REQ-046 L=5 -> one line read; two words sent; eop on word 1 with tx_empty=3; done pulse.
REQ-047 L=0, and separately L=MAX_LEN+1 -> no line read; err pulse; no tx_valid.
REQ-048 rd_valid withheld after the header read -> err exactly TIMEOUT cycles after rd_rq; returns to IDLE, busy=0.
REQ-049 tx_ready toggled randomly with L=0x40 -> every word held stable until accepted; word order and data match the DDR model.
REQ-050 Reset asserted during SEND of the second line -> all outputs take their reset values at once; a subsequent start re-reads the frame from the header.
